axis_pkt_dispatcher: RTL and testbench
======================================

Name: axis_pkt_dispatcher

Overview:
- Downstream consumer of the two-input packet arbiter's merged stream (valid/head/data/start/last/ready).
- Steers each whole packet to one of two output streams based on a route field in the start-beat header; illegal route codes are discarded.
- Each output is registered through a skid buffer so that out ready does not combinationally reach the arbiter.
- Keeps per-destination packet counters and sticky protocol-error flags for debug CSRs.

Parameters:
HEAD_WIDTH, 128, header (tuser) width
DATA_WIDTH, 512, data beat width
SEL_LSB, 0, bit position of route field in head
SEL_WIDTH, 2, route field width; code 0 -> port A, 1 -> port B, all others -> drop
CNT_WIDTH, 32, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_axis_valid  in  1  input beat valid
in_axis_head  in  HEAD_WIDTH  header, meaningful on start beat
in_axis_data  in  DATA_WIDTH  beat data
in_axis_start  in  1  first beat of packet
in_axis_last  in  1  final beat of packet
in_axis_ready  out  1  input accept
out_a_valid / out_b_valid  out  1  output beat valid
out_a_head / out_b_head  out  HEAD_WIDTH  latched packet header, held on every beat
out_a_data / out_b_data  out  DATA_WIDTH  beat data
out_a_start / out_b_start  out  1  first beat
out_a_last / out_b_last  out  1  final beat
out_a_ready / out_b_ready  in  1  downstream accept
pkt_cnt_a / pkt_cnt_b  out  CNT_WIDTH  packets completed per port
drop_cnt  out  CNT_WIDTH  packets discarded (illegal route)
err_no_start  out  1  sticky: beat arrived in IDLE without start
err_dup_start  out  1  sticky: start seen mid-packet

Behaviour:
- Handshake: a beat transfers when valid && ready, on both input and output sides.
- Reset: state IDLE; skid buffers empty; all out_*_valid = 0; counters = 0; error flags = 0.
- States: IDLE, FWD_A, FWD_B, DROP.
- Route decode: combinational from in_axis_head[SEL_LSB +: SEL_WIDTH] on the start beat. The first beat is therefore steered with no bubble.
- in_axis_ready:
  - IDLE with start: follows the target skid's ready (A or B), or 1 for drop.
  - FWD_A / FWD_B: follows that skid's ready.
  - DROP: 1.
  - IDLE without start: 1, so the stray beat is discarded.
- Transitions on an accepted beat:
  - IDLE + start + !last -> FWD_A / FWD_B / DROP per route; head latched.
  - IDLE + start + last (single-beat packet) -> stays IDLE; beat routed; counter bumps.
  - IDLE + !start -> stays IDLE; beat discarded; err_no_start set.
  - FWD_x / DROP + last -> IDLE; the respective counter increments on that cycle.
  - FWD_x / DROP + start -> err_dup_start set; beat treated as a continuation of the current packet. It is forwarded with out start forced to 0 and the latched head. State is unchanged unless last is also set.
- Output head: the start-beat head on the start beat, the latched head on later beats.
- Skid buffers:
  - 2-entry; latency exactly 1 cycle from input accept to out valid.
  - Full throughput of 1 beat/cycle under continuous ready.
  - Skid ready = !full, registered.
  - Outputs stay stable while valid && !ready.
- Counters: increment on last-beat accept (for A/B, at skid input), saturate at all-ones, with no wrap.
- Order: packets to the same port stay in order; A and B progress independently, so back-pressure on B never stalls already-queued A beats.
- Errors: flags are sticky until rst; they cause no stall.
- Reset mid-packet: partial packet abandoned, skids flushed, out valids drop to 0 asynchronously.

Decomposition:
- Shared package/header: route code constants (ROUTE_A = 0, ROUTE_B = 1) and state encodings, added to protocol_engine_def.vh.
- Sub-module axis_skid_buf (params HEAD_WIDTH, DATA_WIDTH), instantiated twice.

Test Plan:
- 3-beat packet with route 0, both readys held 1 -> out_a shows 3 beats starting 1 cycle after input; start on beat 0, last on beat 2; head constant; pkt_cnt_a = 1; out_b_valid stays 0.
- Back-to-back single-beat packets alternating route 0/1 for 8 cycles -> in_axis_ready stays 1; pkt_cnt_a = 4; pkt_cnt_b = 4; no bubbles.
- Route 1 packet, 4 beats, out_b_ready toggling 1010 -> no beat lost or duplicated; data sequence preserved; in_axis_ready deasserts within 1 cycle of skid full.
- Route 3 packet, 5 beats -> all accepted with ready = 1; no output valid; drop_cnt = 1.
- Beat without start in IDLE, then a 2-beat packet whose second beat has start = 1 -> err_no_start = 1; err_dup_start = 1; forwarded packet shows a single start; counter +1.
- rst asserted mid-packet with B skid full -> all out valids 0 immediately; counters 0; next packet routes correctly.

Source files
------------

// File: rtl/axis_pkt_dispatcher_pkg.sv
// Shared definitions for the packet dispatcher: route codes, FSM states and
// the internal destination selector.
package axis_pkt_dispatcher_pkg;

  localparam int ROUTE_A = 0;
  localparam int ROUTE_B = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD_A = 2'd1,
    ST_FWD_B = 2'd2,
    ST_DROP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_A    = 2'd1,
    DEST_B    = 2'd2
  } dest_e;

endpackage

// File: rtl/axis_pkt_dispatcher_skid_buf.sv
// Two-entry skid buffer: one output register plus one overflow register, so
// the upstream ready is a flop and never sees the downstream ready.
module axis_skid_buf #(
  parameter int HEAD_WIDTH = 128,
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [HEAD_WIDTH-1:0] in_head,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_start,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [HEAD_WIDTH-1:0] out_head,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_start,
  output logic                  out_last
);

  localparam int PW = HEAD_WIDTH + DATA_WIDTH + 2;

  logic          out_valid_q, out_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] out_q, out_d;
  logic [PW-1:0] skid_q, skid_d;
  logic [PW-1:0] in_payload;
  logic          push, pop;

  assign in_payload = {in_head, in_data, in_start, in_last};
  assign in_ready   = !skid_valid_q;
  assign out_valid  = out_valid_q;
  assign {out_head, out_data, out_start, out_last} = out_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    push         = in_valid && !skid_valid_q;
    pop          = out_valid_q && out_ready;
    if (skid_valid_q) begin
      if (pop) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!out_valid_q || pop) begin
      out_valid_d = push;
      if (push) begin
        out_d = in_payload;
      end
    end else if (push) begin
      // Output is stalled: park the beat so upstream sees ready drop next cycle.
      skid_valid_d = 1'b1;
      skid_d       = in_payload;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    out_q  <= out_d;
    skid_q <= skid_d;
  end

endmodule

// File: rtl/axis_pkt_dispatcher.sv
// Steers whole packets from the merged arbiter stream to port A or B by the
// start-beat route field, dropping illegal routes and keeping debug counters.
module axis_pkt_dispatcher
  import axis_pkt_dispatcher_pkg::*;
#(
  parameter int HEAD_WIDTH = 128,
  parameter int DATA_WIDTH = 512,
  parameter int SEL_LSB    = 0,
  parameter int SEL_WIDTH  = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_axis_valid,
  input  logic [HEAD_WIDTH-1:0] in_axis_head,
  input  logic [DATA_WIDTH-1:0] in_axis_data,
  input  logic                  in_axis_start,
  input  logic                  in_axis_last,
  output logic                  in_axis_ready,
  output logic                  out_a_valid,
  output logic [HEAD_WIDTH-1:0] out_a_head,
  output logic [DATA_WIDTH-1:0] out_a_data,
  output logic                  out_a_start,
  output logic                  out_a_last,
  input  logic                  out_a_ready,
  output logic                  out_b_valid,
  output logic [HEAD_WIDTH-1:0] out_b_head,
  output logic [DATA_WIDTH-1:0] out_b_data,
  output logic                  out_b_start,
  output logic                  out_b_last,
  input  logic                  out_b_ready,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_a,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_b,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  err_no_start,
  output logic                  err_dup_start
);

  state_e                state_q, state_d;
  logic [HEAD_WIDTH-1:0] head_q, head_d;
  logic [CNT_WIDTH-1:0]  cnt_a_q, cnt_a_d;
  logic [CNT_WIDTH-1:0]  cnt_b_q, cnt_b_d;
  logic [CNT_WIDTH-1:0]  cnt_drop_q, cnt_drop_d;
  logic                  err_no_start_q, err_no_start_d;
  logic                  err_dup_start_q, err_dup_start_d;

  logic [SEL_WIDTH-1:0]  route;
  dest_e                 start_dest, dest;
  logic                  accept, in_idle;
  logic                  a_in_ready, b_in_ready;
  logic                  a_in_valid, b_in_valid;
  logic [HEAD_WIDTH-1:0] fwd_head;
  logic                  fwd_start;

  assign route = in_axis_head[SEL_LSB +: SEL_WIDTH];

  always_comb begin
    state_d         = state_q;
    head_d          = head_q;
    cnt_a_d         = cnt_a_q;
    cnt_b_d         = cnt_b_q;
    cnt_drop_d      = cnt_drop_q;
    err_no_start_d  = err_no_start_q;
    err_dup_start_d = err_dup_start_q;
    in_idle         = (state_q == ST_IDLE);

    if (route == SEL_WIDTH'(ROUTE_A)) begin
      start_dest = DEST_A;
    end else if (route == SEL_WIDTH'(ROUTE_B)) begin
      start_dest = DEST_B;
    end else begin
      start_dest = DEST_NONE;
    end

    case (state_q)
      ST_IDLE:  dest = in_axis_start ? start_dest : DEST_NONE;
      ST_FWD_A: dest = DEST_A;
      ST_FWD_B: dest = DEST_B;
      default:  dest = DEST_NONE;
    endcase

    case (dest)
      DEST_A:  in_axis_ready = a_in_ready;
      DEST_B:  in_axis_ready = b_in_ready;
      default: in_axis_ready = 1'b1;
    endcase

    accept     = in_axis_valid && in_axis_ready;
    a_in_valid = in_axis_valid && (dest == DEST_A);
    b_in_valid = in_axis_valid && (dest == DEST_B);
    // A start seen mid-packet is folded into the current packet.
    fwd_head   = in_idle ? in_axis_head : head_q;
    fwd_start  = in_idle && in_axis_start;

    if (accept) begin
      if (in_idle) begin
        if (!in_axis_start) begin
          err_no_start_d = 1'b1;
        end else begin
          head_d = in_axis_head;
          if (!in_axis_last) begin
            case (start_dest)
              DEST_A:  state_d = ST_FWD_A;
              DEST_B:  state_d = ST_FWD_B;
              default: state_d = ST_DROP;
            endcase
          end
        end
      end else begin
        if (in_axis_start) begin
          err_dup_start_d = 1'b1;
        end
        if (in_axis_last) begin
          state_d = ST_IDLE;
        end
      end

      // Stray IDLE beats are not packets, so they never reach a counter.
      if (in_axis_last && (!in_idle || in_axis_start)) begin
        case (dest)
          DEST_A: if (cnt_a_q != '1) cnt_a_d = cnt_a_q + CNT_WIDTH'(1);
          DEST_B: if (cnt_b_q != '1) cnt_b_d = cnt_b_q + CNT_WIDTH'(1);
          default: if (cnt_drop_q != '1) cnt_drop_d = cnt_drop_q + CNT_WIDTH'(1);
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      head_q          <= '0;
      cnt_a_q         <= '0;
      cnt_b_q         <= '0;
      cnt_drop_q      <= '0;
      err_no_start_q  <= 1'b0;
      err_dup_start_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      head_q          <= head_d;
      cnt_a_q         <= cnt_a_d;
      cnt_b_q         <= cnt_b_d;
      cnt_drop_q      <= cnt_drop_d;
      err_no_start_q  <= err_no_start_d;
      err_dup_start_q <= err_dup_start_d;
    end
  end

  assign pkt_cnt_a     = cnt_a_q;
  assign pkt_cnt_b     = cnt_b_q;
  assign drop_cnt      = cnt_drop_q;
  assign err_no_start  = err_no_start_q;
  assign err_dup_start = err_dup_start_q;

  axis_skid_buf #(
    .HEAD_WIDTH(HEAD_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid_a (
    .clk      (clk),
    .rst      (rst),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .in_head  (fwd_head),
    .in_data  (in_axis_data),
    .in_start (fwd_start),
    .in_last  (in_axis_last),
    .out_valid(out_a_valid),
    .out_ready(out_a_ready),
    .out_head (out_a_head),
    .out_data (out_a_data),
    .out_start(out_a_start),
    .out_last (out_a_last)
  );

  axis_skid_buf #(
    .HEAD_WIDTH(HEAD_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid_b (
    .clk      (clk),
    .rst      (rst),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_head  (fwd_head),
    .in_data  (in_axis_data),
    .in_start (fwd_start),
    .in_last  (in_axis_last),
    .out_valid(out_b_valid),
    .out_ready(out_b_ready),
    .out_head (out_b_head),
    .out_data (out_b_data),
    .out_start(out_b_start),
    .out_last (out_b_last)
  );

endmodule

// File: tb/tb_axis_pkt_dispatcher.sv
// Bench for axis_pkt_dispatcher: directed packets, a queue-based packet model
// checked every cycle, and literal expectations on counters and flags.
module tb_axis_pkt_dispatcher;

  localparam int HW = 128;
  localparam int DW = 512;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_axis_valid = 1'b0;
  logic [HW-1:0] in_axis_head = '0;
  logic [DW-1:0] in_axis_data = '0;
  logic          in_axis_start = 1'b0;
  logic          in_axis_last = 1'b0;
  logic          in_axis_ready;
  logic          out_a_valid, out_a_start, out_a_last;
  logic [HW-1:0] out_a_head;
  logic [DW-1:0] out_a_data;
  logic          out_a_ready = 1'b1;
  logic          out_b_valid, out_b_start, out_b_last;
  logic [HW-1:0] out_b_head;
  logic [DW-1:0] out_b_data;
  logic          out_b_ready = 1'b1;
  logic [CW-1:0] pkt_cnt_a, pkt_cnt_b, drop_cnt;
  logic          err_no_start, err_dup_start;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  axis_pkt_dispatcher #(
    .HEAD_WIDTH(HW), .DATA_WIDTH(DW), .SEL_LSB(0), .SEL_WIDTH(2), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_axis_valid(in_axis_valid), .in_axis_head(in_axis_head),
    .in_axis_data(in_axis_data), .in_axis_start(in_axis_start),
    .in_axis_last(in_axis_last), .in_axis_ready(in_axis_ready),
    .out_a_valid(out_a_valid), .out_a_head(out_a_head), .out_a_data(out_a_data),
    .out_a_start(out_a_start), .out_a_last(out_a_last), .out_a_ready(out_a_ready),
    .out_b_valid(out_b_valid), .out_b_head(out_b_head), .out_b_data(out_b_data),
    .out_b_start(out_b_start), .out_b_last(out_b_last), .out_b_ready(out_b_ready),
    .pkt_cnt_a(pkt_cnt_a), .pkt_cnt_b(pkt_cnt_b), .drop_cnt(drop_cnt),
    .err_no_start(err_no_start), .err_dup_start(err_dup_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- packet-level model ----------------
  typedef struct {
    logic [HW-1:0] head;
    logic [DW-1:0] data;
    logic          start;
    logic          last;
  } beat_t;

  beat_t         qa[$];
  beat_t         qb[$];
  int            m_pkt;       // 0: between packets, 1: to A, 2: to B, 3: discarding
  logic [HW-1:0] m_head;
  logic [CW-1:0] m_cnt_a, m_cnt_b, m_cnt_drop;
  logic          m_err_ns, m_err_ds;

  function automatic int route_port(input logic [HW-1:0] h);
    if (h[1:0] == 2'd0) return 1;
    if (h[1:0] == 2'd1) return 2;
    return 3;
  endfunction

  function automatic logic [CW-1:0] bump(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + 1;
  endfunction

  always @(negedge clk) begin : compare
    logic  exp_rdy;
    int    port;
    beat_t b;
    if (rst) begin
      qa.delete();
      qb.delete();
      m_pkt = 0;
      m_head = '0;
      m_cnt_a = '0;
      m_cnt_b = '0;
      m_cnt_drop = '0;
      m_err_ns = 1'b0;
      m_err_ds = 1'b0;
      chk("rst_a_valid", out_a_valid, 0);
      chk("rst_b_valid", out_b_valid, 0);
    end else begin
      port = (m_pkt != 0) ? m_pkt : (in_axis_start ? route_port(in_axis_head) : 3);
      exp_rdy = (port == 1) ? (qa.size() < 2) : (port == 2) ? (qb.size() < 2) : 1'b1;
      chk("in_ready", in_axis_ready, exp_rdy);

      chk("a_valid", out_a_valid, qa.size() != 0);
      if (out_a_valid && qa.size() != 0) begin
        chk("a_head", out_a_head, qa[0].head);
        chk("a_data", out_a_data, qa[0].data);
        chk("a_start", out_a_start, qa[0].start);
        chk("a_last", out_a_last, qa[0].last);
        if (out_a_ready) void'(qa.pop_front());
      end
      chk("b_valid", out_b_valid, qb.size() != 0);
      if (out_b_valid && qb.size() != 0) begin
        chk("b_head", out_b_head, qb[0].head);
        chk("b_data", out_b_data, qb[0].data);
        chk("b_start", out_b_start, qb[0].start);
        chk("b_last", out_b_last, qb[0].last);
        if (out_b_ready) void'(qb.pop_front());
      end

      chk("cnt_a", pkt_cnt_a, m_cnt_a);
      chk("cnt_b", pkt_cnt_b, m_cnt_b);
      chk("cnt_drop", drop_cnt, m_cnt_drop);
      chk("err_ns", err_no_start, m_err_ns);
      chk("err_ds", err_dup_start, m_err_ds);

      if (in_axis_valid && exp_rdy) begin
        b.data = in_axis_data;
        b.last = in_axis_last;
        if (m_pkt == 0 && !in_axis_start) begin
          m_err_ns = 1'b1;
        end else begin
          if (m_pkt == 0) begin
            m_head = in_axis_head;
            b.start = 1'b1;
          end else begin
            if (in_axis_start) m_err_ds = 1'b1;
            b.start = 1'b0;
          end
          b.head = m_head;
          if (port == 1) qa.push_back(b);
          if (port == 2) qb.push_back(b);
          if (in_axis_last) begin
            if (port == 1) m_cnt_a = bump(m_cnt_a);
            else if (port == 2) m_cnt_b = bump(m_cnt_b);
            else m_cnt_drop = bump(m_cnt_drop);
            m_pkt = 0;
          end else begin
            m_pkt = port;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [HW-1:0] mk_head(input int tag, input int route);
    logic [HW-1:0] h;
    h = '0;
    h[1:0] = route[1:0];
    h[15:8] = tag[7:0];
    h[HW-1:HW-8] = 8'hA5;
    return h;
  endfunction

  task automatic send(input logic [HW-1:0] h, input logic [DW-1:0] d, input logic s, input logic l);
    int n;
    n = 0;
    in_axis_valid = 1'b1;
    in_axis_head  = h;
    in_axis_data  = d;
    in_axis_start = s;
    in_axis_last  = l;
    @(negedge clk);
    while (!in_axis_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_axis_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    in_axis_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t0;

  initial begin
    idle(3);
    chk("rst_cnt_a", pkt_cnt_a, 0);
    chk("rst_err_ns", err_no_start, 0);
    rst = 1'b0;
    idle(2);

    // 3-beat packet to A
    send(mk_head(1, 0), 512'h100, 1, 0);
    chk("t1_first_valid", out_a_valid, 1);
    chk("t1_first_start", out_a_start, 1);
    send(mk_head(1, 0), 512'h101, 0, 0);
    send(mk_head(1, 0), 512'h102, 0, 1);
    idle(4);
    chk("t1_cnt_a", pkt_cnt_a, 1);
    chk("t1_b_valid", out_b_valid, 0);

    // alternating single-beat packets, one per cycle
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(mk_head(16 + i, i % 2), DW'(512'h200 + i), 1, 1);
    chk("t2_cycles", cyc - t0, 8);
    idle(4);
    chk("t2_cnt_a", pkt_cnt_a, 5);
    chk("t2_cnt_b", pkt_cnt_b, 4);

    // 4-beat packet to B with toggling downstream ready
    fork
      begin
        send(mk_head(3, 1), 512'h300, 1, 0);
        send(mk_head(3, 1), 512'h301, 0, 0);
        send(mk_head(3, 1), 512'h302, 0, 0);
        send(mk_head(3, 1), 512'h303, 0, 1);
      end
      begin
        for (int i = 0; i < 8; i++) begin
          out_b_ready = (i % 2 == 0);
          @(posedge clk);
          #1;
        end
        out_b_ready = 1'b1;
      end
    join
    idle(6);
    chk("t3_cnt_b", pkt_cnt_b, 5);
    chk("t3_drained", out_b_valid, 0);

    // illegal route 3, 5 beats
    for (int i = 0; i < 5; i++) send(mk_head(4, 3), DW'(512'h400 + i), i == 0, i == 4);
    idle(3);
    chk("t4_drop", drop_cnt, 1);
    chk("t4_cnt_a", pkt_cnt_a, 5);

    // stray beat, then a packet with a repeated start
    send(mk_head(5, 0), 512'h500, 0, 0);
    send(mk_head(6, 0), 512'h600, 1, 0);
    send(mk_head(7, 1), 512'h601, 1, 1);
    idle(4);
    chk("t5_err_ns", err_no_start, 1);
    chk("t5_err_ds", err_dup_start, 1);
    chk("t5_cnt_a", pkt_cnt_a, 6);
    chk("t5_cnt_b", pkt_cnt_b, 5);

    // reset with B skid full mid-packet
    out_b_ready = 1'b0;
    send(mk_head(8, 1), 512'h800, 1, 0);
    send(mk_head(8, 1), 512'h801, 0, 0);
    in_axis_valid = 1'b1;
    in_axis_data  = 512'h802;
    in_axis_start = 1'b0;
    in_axis_last  = 1'b0;
    @(negedge clk);
    chk("t6_full_ready", in_axis_ready, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_b_valid_async", out_b_valid, 0);
    chk("t6_cnt_a", pkt_cnt_a, 0);
    chk("t6_err_ds", err_dup_start, 0);
    in_axis_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_b_ready = 1'b1;
    send(mk_head(9, 1), 512'h900, 1, 1);
    chk("t6_post_b_valid", out_b_valid, 1);
    chk("t6_post_b_data", out_b_data, 512'h900);
    idle(3);
    chk("t6_post_cnt_b", pkt_cnt_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
